// File: rtl/vm1_bus_pkg.sv
// Shared 1801VM1 system-bus definitions: arbiter state encoding, bus owner
// encoding, the latched transfer record and the default reply timeout.
package vm1_bus_pkg;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_REL, S_ERR} state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

  localparam int BUS_TIMEOUT_DEF = 63;

  // Transfer captured at arbitration time and held for the whole bus cycle.
  typedef struct packed {
    owner_t      owner;
    logic        we;
    logic        bt;
    logic [15:0] addr;
    logic [15:0] wdata;
  } xfer_t;

  // Counter width able to hold the timeout load value (at least one bit).
  function automatic int timer_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/qbus_arbiter_if.sv
// Request/bus bundle of qbus_arbiter. "slave" is the arbiter side (it serves
// the CPU and DMA requesters); "master" is the requester/bus-slave side.
interface qbus_arbiter_if;
  logic        cpu_dati, cpu_dato, cpu_byte;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_done;
  logic        dma_req, dma_we, dma_byte;
  logic [15:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_done;
  logic [15:0] rdata;
  logic        xfer_err;
  logic        SYNC, DIN, DOUT, WTBT, BSY;
  logic [15:0] addr_o, data_o, data_i;
  logic        RPLY;

  modport slave (
    input  cpu_dati, cpu_dato, cpu_byte, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_byte, dma_addr, dma_wdata,
    input  data_i, RPLY,
    output cpu_done, dma_gnt, dma_done, rdata, xfer_err,
    output SYNC, DIN, DOUT, WTBT, BSY, addr_o, data_o
  );

  modport master (
    output cpu_dati, cpu_dato, cpu_byte, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_byte, dma_addr, dma_wdata,
    output data_i, RPLY,
    input  cpu_done, dma_gnt, dma_done, rdata, xfer_err,
    input  SYNC, DIN, DOUT, WTBT, BSY, addr_o, data_o
  );
endinterface

// File: rtl/bus_timer.sv
// Loadable down-counter used as the data-phase reply watchdog. Stops at zero;
// load has priority over enable.
module bus_timer #(
  parameter int           W    = 6,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: reload, or count down while enabled and not yet at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = INIT;
    else if (en && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  // count register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/qbus_arbiter.sv
// Two-master (CPU / DMA) arbiter and cycle sequencer for the 1801VM1 bus.
// Each transfer runs address phase, data phase, reply release; all bus
// strobes and status outputs are registered and advance only on ce.
// Macro QBUS_ARB_TIMEOUT_EN adds the RPLY watchdog and the S_ERR path;
// without it the data phase waits for RPLY forever and xfer_err stays 0.
module qbus_arbiter
  import vm1_bus_pkg::*;
#(
  parameter int BUS_TIMEOUT = BUS_TIMEOUT_DEF
) (
  input logic          clk,
  input logic          reset_n,
  input logic          ce,
  qbus_arbiter_if.slave bus
);

  state_t      state_q, state_d;
  xfer_t       req_q, req_d;
  logic        sync_q, sync_d, din_q, din_d, dout_q, dout_d, wtbt_q, wtbt_d;
  logic        gnt_q, gnt_d, cdone_q, cdone_d, ddone_q, ddone_d, err_q, err_d;
  logic [15:0] addr_q, addr_d, wdat_q, wdat_d, rdata_q, rdata_d;
  xfer_t       cpu_x, dma_x;
  logic        tmr_zero;

  // read wins when the CPU raises both dati and dato
  assign cpu_x = '{owner: OWN_CPU, we: bus.cpu_dato & ~bus.cpu_dati, bt: bus.cpu_byte,
                   addr: bus.cpu_addr, wdata: bus.cpu_wdata};
  assign dma_x = '{owner: OWN_DMA, we: bus.dma_we, bt: bus.dma_byte,
                   addr: bus.dma_addr, wdata: bus.dma_wdata};

`ifdef QBUS_ARB_TIMEOUT_EN
  localparam int            TW    = timer_width(BUS_TIMEOUT);
  localparam logic [TW-1:0] TLOAD = TW'(BUS_TIMEOUT);

  logic tmr_load, tmr_en;
  assign tmr_load = ce && (state_q == S_IDLE) && (state_d == S_ADDR);
  assign tmr_en   = ce && (state_q == S_DATA) && !bus.RPLY;

  bus_timer #(.W(TW), .INIT(TLOAD)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (tmr_load),
    .en     (tmr_en),
    .zero   (tmr_zero)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^BUS_TIMEOUT;
  assign tmr_zero       = 1'b0;
`endif

  // sequencer next state; outputs are computed for the state being entered
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    sync_d  = sync_q;
    din_d   = din_q;
    dout_d  = dout_q;
    wtbt_d  = wtbt_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    cdone_d = 1'b0;
    ddone_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (bus.dma_req || bus.cpu_dati || bus.cpu_dato) begin
        req_d   = bus.dma_req ? dma_x : cpu_x;
        state_d = S_ADDR;
        sync_d  = 1'b1;
        wtbt_d  = req_d.bt;
        addr_d  = req_d.addr;
        wdat_d  = req_d.we ? req_d.wdata : 16'h0;
        gnt_d   = (req_d.owner == OWN_DMA);
      end
      S_ADDR: begin
        state_d = S_DATA;
        wtbt_d  = 1'b0;
        din_d   = ~req_q.we;
        dout_d  = req_q.we;
      end
      S_DATA: begin
        // RPLY beats an expiring watchdog in the same cycle
        if (bus.RPLY || tmr_zero) begin
          if (bus.RPLY && !req_q.we) rdata_d = bus.data_i;
          cdone_d = (req_q.owner == OWN_CPU);
          ddone_d = (req_q.owner == OWN_DMA);
          err_d   = !bus.RPLY;
          sync_d  = 1'b0;
          din_d   = 1'b0;
          dout_d  = 1'b0;
          state_d = bus.RPLY ? S_REL : S_ERR;
        end
      end
      S_REL: if (!bus.RPLY) begin
        state_d = S_IDLE;
        gnt_d   = 1'b0;
      end
      S_ERR: begin
        state_d = S_IDLE;
        gnt_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and registered outputs, frozen while ce is low
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      sync_q  <= 1'b0;
      din_q   <= 1'b0;
      dout_q  <= 1'b0;
      wtbt_q  <= 1'b0;
      gnt_q   <= 1'b0;
      cdone_q <= 1'b0;
      ddone_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 16'h0;
      wdat_q  <= 16'h0;
      rdata_q <= 16'h0;
    end else if (ce) begin
      state_q <= state_d;
      req_q   <= req_d;
      sync_q  <= sync_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      wtbt_q  <= wtbt_d;
      gnt_q   <= gnt_d;
      cdone_q <= cdone_d;
      ddone_q <= ddone_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
    end

  assign bus.SYNC     = sync_q;
  assign bus.BSY      = sync_q;
  assign bus.DIN      = din_q;
  assign bus.DOUT     = dout_q;
  assign bus.WTBT     = wtbt_q;
  assign bus.dma_gnt  = gnt_q;
  assign bus.cpu_done = cdone_q;
  assign bus.dma_done = ddone_q;
  assign bus.xfer_err = err_q;
  assign bus.addr_o   = addr_q;
  assign bus.data_o   = wdat_q;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_qbus_arbiter.sv
// Bench for qbus_arbiter: cycle table, hand-written corner sequences and a
// randomized run against a transaction-level model (priority queue of
// expected transfers plus a shadow memory).
module tb_qbus_arbiter;
  import vm1_bus_pkg::*;

  logic clk = 1'b0, reset_n = 1'b0, ce = 1'b0;
  always #5 clk = ~clk;

  qbus_arbiter_if bus();
  qbus_arbiter #(.BUS_TIMEOUT(63)) dut (.clk(clk), .reset_n(reset_n), .ce(ce), .bus(bus));

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ctl = {ce, cpu_dati, cpu_dato, dma_req, RPLY}
  // exp = {SYNC, DIN, DOUT, WTBT, dma_gnt, cpu_done, dma_done}
  typedef struct {
    logic [4:0]  ctl;
    logic [6:0]  exp;
    logic [15:0] erd, ea, caddr, cwd, din;
    logic        cbyte;
  } vec_t;
  vec_t vt[$];
  logic [15:0] sc_caddr, sc_cwd, sc_din;
  logic        sc_cbyte;

  task automatic add(input logic [4:0] ctl, input logic [6:0] exp,
                     input logic [15:0] erd, input logic [15:0] ea);
    vec_t v;
    v.ctl = ctl; v.exp = exp; v.erd = erd; v.ea = ea;
    v.caddr = sc_caddr; v.cwd = sc_cwd; v.cbyte = sc_cbyte; v.din = sc_din;
    vt.push_back(v);
  endtask

  typedef struct { logic dma; logic we; logic bt; logic [15:0] addr; logic [15:0] wd; } tr_t;
  tr_t         q[$];
  tr_t         cur, tc, td;
  logic [15:0] mem[8], shadow[8];
  int          k, cyc, dly, hold;
  logic        p_sync, p_dir, p_done, seen, wc, wd;

  function automatic int idx(input logic [15:0] a);
    return int'(a[3:1]);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.cpu_dati = 0; bus.cpu_dato = 0; bus.cpu_byte = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_byte = 0; bus.dma_addr = 16'h0200; bus.dma_wdata = 0;
    bus.RPLY = 0; bus.data_i = 0;
    reset_n = 0; ce = 1;
    @(negedge clk);
    chk("reset_strobes", {bus.SYNC, bus.DIN, bus.DOUT, bus.WTBT, bus.BSY, bus.dma_gnt,
                          bus.cpu_done, bus.dma_done, bus.xfer_err}, 0);
    chk("reset_buses", {bus.addr_o, bus.data_o}, 0);
    chk("reset_rdata", bus.rdata, 0);
    reset_n = 1;
    repeat (2) @(negedge clk);

    // A: CPU read of 0o100000, reply with 0o012345
    sc_caddr = 16'o100000; sc_cwd = 0; sc_cbyte = 0; sc_din = 16'o012345;
    add(5'b11000, 7'b1000000, 16'h0, 16'o100000);
    add(5'b11000, 7'b1100000, 16'h0, 16'o100000);
    add(5'b11000, 7'b1100000, 16'h0, 16'o100000);
    add(5'b11000, 7'b1100000, 16'h0, 16'o100000);
    add(5'b11001, 7'b0000010, 16'o012345, 0);
    add(5'b10000, 7'b0000000, 16'o012345, 0);
    add(5'b10000, 7'b0000000, 16'o012345, 0);
    // B: CPU write and DMA read together; DMA first, RPLY held 4 cycles
    sc_caddr = 16'h0100; sc_cwd = 16'hBEEF; sc_din = 16'h1111;
    add(5'b10110, 7'b1000100, 16'o012345, 16'h0200);
    add(5'b10110, 7'b1100100, 16'o012345, 16'h0200);
    add(5'b10111, 7'b0000101, 16'h1111, 0);
    repeat (4) add(5'b10101, 7'b0000100, 16'h1111, 0);
    add(5'b10100, 7'b0000000, 16'h1111, 0);
    add(5'b10100, 7'b1000000, 16'h1111, 16'h0100);
    add(5'b10100, 7'b1010000, 16'h1111, 16'h0100);
    add(5'b10101, 7'b0000010, 16'h1111, 0);
    add(5'b10000, 7'b0000000, 16'h1111, 0);
    // C: CPU byte write with ce gaps
    sc_caddr = 16'h0003; sc_cwd = 16'h00A5; sc_cbyte = 1; sc_din = 16'h0;
    add(5'b10100, 7'b1001000, 16'h1111, 16'h0003);
    add(5'b00100, 7'b1001000, 16'h1111, 16'h0003);
    add(5'b10100, 7'b1010000, 16'h1111, 16'h0003);
    add(5'b00101, 7'b1010000, 16'h1111, 16'h0003);
    add(5'b10101, 7'b0000010, 16'h1111, 0);
    add(5'b00000, 7'b0000010, 16'h1111, 0);
    add(5'b10000, 7'b0000000, 16'h1111, 0);

    foreach (vt[i]) begin
      ce = vt[i].ctl[4]; bus.cpu_dati = vt[i].ctl[3]; bus.cpu_dato = vt[i].ctl[2];
      bus.dma_req = vt[i].ctl[1]; bus.RPLY = vt[i].ctl[0]; bus.data_i = vt[i].din;
      bus.cpu_addr = vt[i].caddr; bus.cpu_wdata = vt[i].cwd; bus.cpu_byte = vt[i].cbyte;
      @(negedge clk);
      chk($sformatf("tbl%0d_out", i), {bus.SYNC, bus.DIN, bus.DOUT, bus.WTBT, bus.dma_gnt,
                                       bus.cpu_done, bus.dma_done}, vt[i].exp);
      chk($sformatf("tbl%0d_bsy_err", i), {bus.BSY, bus.xfer_err}, {vt[i].exp[6], 1'b0});
      chk($sformatf("tbl%0d_rdata", i), bus.rdata, vt[i].erd);
      if (vt[i].exp[6]) chk($sformatf("tbl%0d_addr", i), bus.addr_o, vt[i].ea);
      if (vt[i].exp[4]) chk($sformatf("tbl%0d_wdata", i), bus.data_o, vt[i].cwd);
    end
    ce = 1; bus.cpu_byte = 0;

    // no RPLY at all
    bus.cpu_addr = 16'h0040; bus.cpu_dati = 1;
    k = 0;
    while (!bus.DIN && k < 10) begin @(negedge clk); k++; end
    chk("to_din_up", bus.DIN, 1);
    k = 0;
`ifdef QBUS_ARB_TIMEOUT_EN
    while (!bus.xfer_err && k < 200) begin @(negedge clk); k++; end
    chk("to_latency", k, 64);
    chk("to_done", {bus.cpu_done, bus.dma_done, bus.xfer_err, bus.SYNC, bus.DIN}, 5'b10100);
    chk("to_rdata", bus.rdata, 16'h1111);
    bus.cpu_dati = 0;
    @(negedge clk);
    chk("to_pulse_end", {bus.cpu_done, bus.xfer_err, bus.SYNC}, 0);
    @(negedge clk);
    // RPLY arrives on the very cycle the watchdog expires
    bus.cpu_dati = 1;
    k = 0;
    while (!bus.DIN && k < 10) begin @(negedge clk); k++; end
    repeat (63) @(negedge clk);
    bus.RPLY = 1; bus.data_i = 16'h5A5A;
    @(negedge clk);
    chk("race_done", {bus.cpu_done, bus.xfer_err}, 2'b10);
    chk("race_rdata", bus.rdata, 16'h5A5A);
    bus.RPLY = 0; bus.cpu_dati = 0;
    @(negedge clk);
`else
    repeat (200) @(negedge clk);
    chk("nto_hold", {bus.SYNC, bus.DIN, bus.xfer_err, bus.cpu_done}, 4'b1100);
    bus.RPLY = 1; bus.data_i = 16'h0777;
    @(negedge clk);
    chk("nto_done", {bus.cpu_done, bus.xfer_err, bus.DIN}, 3'b100);
    chk("nto_rdata", bus.rdata, 16'h0777);
    bus.RPLY = 0; bus.cpu_dati = 0;
    @(negedge clk);
`endif
    @(negedge clk);

    // asynchronous reset during the DMA data phase
    bus.dma_addr = 16'h0300; bus.dma_we = 0; bus.dma_req = 1;
    k = 0;
    while (!bus.DIN && k < 10) begin @(negedge clk); k++; end
    chk("rst_din_up", {bus.DIN, bus.dma_gnt}, 2'b11);
    #2 reset_n = 0;
    #1 chk("rst_async", {bus.SYNC, bus.DIN, bus.DOUT, bus.BSY, bus.dma_gnt}, 0);
    chk("rst_rdata", bus.rdata, 0);
    bus.dma_req = 0;
    @(negedge clk);
    reset_n = 1;
    seen = 0;
    repeat (6) begin @(negedge clk); seen |= bus.cpu_done | bus.dma_done | bus.SYNC; end
    chk("rst_no_done", seen, 0);

    // randomized traffic
    for (int i = 0; i < 8; i++) begin mem[i] = 16'h1000 + 16'(i); shadow[i] = mem[i]; end
    dly = $urandom_range(0, 4); hold = $urandom_range(0, 3);
    p_sync = 0; p_dir = 0; p_done = 0;
    for (int it = 0; it < 80; it++) begin
      wc = 1'($urandom_range(0, 1)); wd = 1'($urandom_range(0, 1));
      if (!wc && !wd) wc = 1;
      tc = '{0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom) & 16'hFF0E, 16'($urandom)};
      td = '{1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom) & 16'hFF0E, 16'($urandom)};
      q.delete();
      if (wd) begin
        q.push_back(td);
        bus.dma_req = 1; bus.dma_we = td.we; bus.dma_byte = td.bt;
        bus.dma_addr = td.addr; bus.dma_wdata = td.wd;
      end
      if (wc) begin
        q.push_back(tc);
        bus.cpu_dato = tc.we ? 1'b1 : 1'($urandom_range(0, 1));
        bus.cpu_dati = !tc.we;
        bus.cpu_byte = tc.bt; bus.cpu_addr = tc.addr; bus.cpu_wdata = tc.wd;
      end
      cyc = 0;
      while ((q.size() != 0 || bus.RPLY || bus.SYNC) && cyc < 500) begin
        ce = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        cyc++;
        if (bus.SYNC && !p_sync) begin
          chk("rnd_start_expected", q.size() != 0, 1);
          chk("rnd_start_rply_low", bus.RPLY, 0);
          if (q.size() != 0) begin
            cur = q[0];
            chk("rnd_addr", bus.addr_o, cur.addr);
            chk("rnd_wtbt_gnt", {bus.WTBT, bus.dma_gnt}, {cur.bt, cur.dma});
          end
        end
        if ((bus.DIN || bus.DOUT) && !p_dir) begin
          chk("rnd_dir", {bus.SYNC, bus.DIN, bus.DOUT, bus.dma_gnt}, {1'b1, !cur.we, cur.we, cur.dma});
          if (cur.we) chk("rnd_wdata", bus.data_o, cur.wd);
        end
        if ((bus.cpu_done || bus.dma_done) && !p_done) begin
          chk("rnd_done_owner", {bus.cpu_done, bus.dma_done, bus.xfer_err}, {!cur.dma, cur.dma, 1'b0});
          chk("rnd_done_gnt", bus.dma_gnt, cur.dma);
          if (!cur.we) chk("rnd_rdata", bus.rdata, shadow[idx(cur.addr)]);
          else shadow[idx(cur.addr)] = cur.wd;
          if (q.size() != 0) void'(q.pop_front());
          if (cur.dma) bus.dma_req = 0;
          else begin bus.cpu_dati = 0; bus.cpu_dato = 0; end
        end
        p_sync = bus.SYNC; p_dir = bus.DIN | bus.DOUT; p_done = bus.cpu_done | bus.dma_done;
        // bus slave: reply after a random delay, release after a random hold
        if (!bus.RPLY) begin
          if (bus.DIN || bus.DOUT) begin
            if (dly == 0) begin
              bus.RPLY = 1;
              if (bus.DOUT) mem[idx(bus.addr_o)] = bus.data_o;
              else bus.data_i = mem[idx(bus.addr_o)];
            end else dly--;
          end
        end else if (!bus.SYNC) begin
          if (hold == 0) begin
            bus.RPLY = 0; dly = $urandom_range(0, 4); hold = $urandom_range(0, 3);
          end else hold--;
        end
      end
      chk($sformatf("rnd%0d_drained", it), (cyc < 500) && (q.size() == 0), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
